// File: rtl/plb_lookup_stage.sv
// plb_lookup_stage
// ----------------
// Protection Lookaside Buffer (PLB) lookup stage of the MPT walker. Each
// accepted transaction (SPA, SDID, access type) is matched against a small
// fully-associative PLB. One registered result per transaction is produced:
// a hit carrying an allow/deny decision, or a miss for the walking stages.
// The walking stages refill the PLB through the refill port; flush_i
// invalidates every entry and drops the output register.
//
// Optional feature (macro PLB_PERF_COUNTERS_EN): adds saturating 32-bit
// hit/miss counters (hit_count_o, miss_count_o) that count transferred results.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                invalidate PLB, drop output register
//   s_valid_i / s_ready_o  input handshake
//   s_spa_i, s_sdid_i, s_access_i   lookup request (access 0=r,1=w,2=x,3=rsvd)
//   m_valid_o / m_ready_i  output handshake
//   m_spa_o, m_sdid_o, m_access_o   registered copy of the request
//   m_hit_o, m_allow_o     lookup result (allow meaningful only on hit)
//   refill_valid_i, refill_spa_i, refill_sdid_i, refill_perm_i {x,w,r}
//   hit_count_o, miss_count_o       (PLB_PERF_COUNTERS_EN only)
//
// Handshake: strict valid/ready. A transfer happens on a rising edge where
// valid && ready. The producer holds valid and payload stable until the
// transfer; ready may depend combinationally on the consumer's ready.

module plb_lookup_stage #(
    parameter int SPA_WIDTH   = 56,
    parameter int SDID_WIDTH  = 6,
    parameter int PLB_ENTRIES = 8,
    parameter int PAGE_SHIFT  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [SPA_WIDTH-1:0]  s_spa_i,
    input  logic [SDID_WIDTH-1:0] s_sdid_i,
    input  logic [1:0]            s_access_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [SPA_WIDTH-1:0]  m_spa_o,
    output logic [SDID_WIDTH-1:0] m_sdid_o,
    output logic [1:0]            m_access_o,
    output logic                  m_hit_o,
    output logic                  m_allow_o,
    input  logic                  refill_valid_i,
    input  logic [SPA_WIDTH-1:0]  refill_spa_i,
    input  logic [SDID_WIDTH-1:0] refill_sdid_i,
    input  logic [2:0]            refill_perm_i
`ifdef PLB_PERF_COUNTERS_EN
    ,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
`endif
);

    localparam int VPN_W = SPA_WIDTH - PAGE_SHIFT;
    localparam int TAG_W = VPN_W + SDID_WIDTH;
    localparam int IDX_W = $clog2(PLB_ENTRIES);

    // PLB storage. Only valid bits and the pointer need reset; tag and
    // permission contents are qualified by the valid bit.
    logic [PLB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q  [PLB_ENTRIES];
    logic [2:0]             perm_q [PLB_ENTRIES];
    logic [IDX_W-1:0]       ptr_q;

    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] rf_tag;
    logic             lk_hit;
    logic [2:0]       lk_perm;
    logic             lk_allow;
    logic             rf_hit;
    logic [IDX_W-1:0] rf_idx;
    logic             refill_we;

    // Page-offset bits of the refill address carry no information.
    logic unused_refill_offset;
    assign unused_refill_offset = ^refill_spa_i[PAGE_SHIFT-1:0];

    assign lk_tag    = {s_spa_i[SPA_WIDTH-1:PAGE_SHIFT], s_sdid_i};
    assign rf_tag    = {refill_spa_i[SPA_WIDTH-1:PAGE_SHIFT], refill_sdid_i};
    assign refill_we = refill_valid_i && !flush_i;

    // Lookup. Refill never creates duplicate tags, so at most one entry
    // matches and OR-ing the permissions of matching entries selects it.
    always_comb begin
        lk_hit  = 1'b0;
        lk_perm = 3'b000;
        for (int i = 0; i < PLB_ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == lk_tag)) begin
                lk_hit  = 1'b1;
                lk_perm = lk_perm | perm_q[i];
            end
        end
    end

    always_comb begin
        lk_allow = 1'b0;
        case (s_access_i)
            2'd0:    lk_allow = lk_perm[0];
            2'd1:    lk_allow = lk_perm[1];
            2'd2:    lk_allow = lk_perm[2];
            default: lk_allow = 1'b0;
        endcase
    end

    // Refill tag match: an existing entry is updated in place.
    always_comb begin
        rf_hit = 1'b0;
        rf_idx = '0;
        for (int i = 0; i < PLB_ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == rf_tag)) begin
                rf_hit = 1'b1;
                rf_idx = IDX_W'(i);
            end
        end
    end

    // Valid bits and round-robin replacement pointer. Flush wins over refill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (refill_valid_i && !rf_hit) begin
            valid_q[ptr_q] <= 1'b1;
            ptr_q          <= ptr_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill_we) begin
            if (rf_hit) begin
                perm_q[rf_idx] <= refill_perm_i;
            end else begin
                tag_q[ptr_q]  <= rf_tag;
                perm_q[ptr_q] <= refill_perm_i;
            end
        end
    end

    // Output register. Input is refused during a flush cycle.
    assign s_ready_o = !flush_i && (!m_valid_o || m_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_valid_o  <= 1'b0;
            m_hit_o    <= 1'b0;
            m_allow_o  <= 1'b0;
            m_spa_o    <= '0;
            m_sdid_o   <= '0;
            m_access_o <= 2'd0;
        end else if (flush_i) begin
            m_valid_o <= 1'b0;
            m_hit_o   <= 1'b0;
            m_allow_o <= 1'b0;
        end else if (s_ready_o) begin
            m_valid_o <= s_valid_i;
            if (s_valid_i) begin
                m_spa_o    <= s_spa_i;
                m_sdid_o   <= s_sdid_i;
                m_access_o <= s_access_i;
                m_hit_o    <= lk_hit;
                m_allow_o  <= lk_hit && lk_allow;
            end
        end
    end

`ifdef PLB_PERF_COUNTERS_EN
    logic xfer_out;
    assign xfer_out = m_valid_o && m_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (flush_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (xfer_out) begin
            if (m_hit_o) begin
                if (hit_count_o != 32'hFFFF_FFFF) hit_count_o <= hit_count_o + 32'd1;
            end else begin
                if (miss_count_o != 32'hFFFF_FFFF) miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_plb_lookup_stage.sv
// Testbench for plb_lookup_stage: table-driven lookup/refill vectors plus
// hand-written sequences for replacement wrap, backpressure, flush collisions
// and (when PLB_PERF_COUNTERS_EN is defined) the performance counters.

module tb_plb_lookup_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [55:0] s_spa_i;
    logic [5:0]  s_sdid_i;
    logic [1:0]  s_access_i;
    logic        m_valid_o;
    logic        m_ready_i;
    logic [55:0] m_spa_o;
    logic [5:0]  m_sdid_o;
    logic [1:0]  m_access_o;
    logic        m_hit_o;
    logic        m_allow_o;
    logic        refill_valid_i;
    logic [55:0] refill_spa_i;
    logic [5:0]  refill_sdid_i;
    logic [2:0]  refill_perm_i;
`ifdef PLB_PERF_COUNTERS_EN
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;
`endif

    int total = 0;
    int bad   = 0;

    logic [55:0] exp_q[$];
    logic        sb_en = 1'b0;

    typedef struct {
        logic        rf;
        logic [55:0] rspa;
        logic [5:0]  rsdid;
        logic [2:0]  rperm;
        logic        lv;
        logic [55:0] spa;
        logic [5:0]  sdid;
        logic [1:0]  acc;
        logic        ehit;
        logic        eallow;
    } vec_t;

    vec_t tbl [9];

    plb_lookup_stage dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .s_spa_i        (s_spa_i),
        .s_sdid_i       (s_sdid_i),
        .s_access_i     (s_access_i),
        .m_valid_o      (m_valid_o),
        .m_ready_i      (m_ready_i),
        .m_spa_o        (m_spa_o),
        .m_sdid_o       (m_sdid_o),
        .m_access_o     (m_access_o),
        .m_hit_o        (m_hit_o),
        .m_allow_o      (m_allow_o),
        .refill_valid_i (refill_valid_i),
        .refill_spa_i   (refill_spa_i),
        .refill_sdid_i  (refill_sdid_i),
        .refill_perm_i  (refill_perm_i)
`ifdef PLB_PERF_COUNTERS_EN
        ,
        .hit_count_o    (hit_count_o),
        .miss_count_o   (miss_count_o)
`endif
    );

    // Clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_refill(input logic [55:0] spa, input logic [5:0] sdid,
                                       input logic [2:0] perm);
        vec_t v;
        v = '{rf: 1'b1, rspa: spa, rsdid: sdid, rperm: perm, lv: 1'b0, spa: '0,
              sdid: '0, acc: 2'd0, ehit: 1'b0, eallow: 1'b0};
        return v;
    endfunction

    function automatic vec_t mk_look(input logic [55:0] spa, input logic [5:0] sdid,
                                     input logic [1:0] acc, input logic hit, input logic allow);
        vec_t v;
        v = '{rf: 1'b0, rspa: '0, rsdid: '0, rperm: 3'b000, lv: 1'b1, spa: spa,
              sdid: sdid, acc: acc, ehit: hit, eallow: allow};
        return v;
    endfunction

    // Scoreboard for the backpressure sequence: sampled on the falling edge,
    // where valid && ready means a transfer at the next rising edge.
    always @(negedge clk_i) begin
        if (sb_en && m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL bp_extra: got %0h expected none", m_spa_o);
            end else begin
                check("bp_order", m_spa_o, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic do_vec(input vec_t v, input string tag);
        refill_valid_i = v.rf;
        refill_spa_i   = v.rspa;
        refill_sdid_i  = v.rsdid;
        refill_perm_i  = v.rperm;
        s_valid_i      = v.lv;
        s_spa_i        = v.spa;
        s_sdid_i       = v.sdid;
        s_access_i     = v.acc;
        m_ready_i      = 1'b1;
        @(posedge clk_i);
        #1;
        refill_valid_i = 1'b0;
        s_valid_i      = 1'b0;
        check({tag, "_valid"}, m_valid_o, v.lv);
        if (v.lv) begin
            check({tag, "_hit"}, m_hit_o, v.ehit);
            check({tag, "_allow"}, m_allow_o, v.eallow);
            check({tag, "_spa"}, m_spa_o, v.spa);
            check({tag, "_sdid"}, m_sdid_o, v.sdid);
            check({tag, "_acc"}, m_access_o, v.acc);
        end
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic idle_cycle();
        s_valid_i      = 1'b0;
        refill_valid_i = 1'b0;
        m_ready_i      = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [55:0] page(input int k);
        return 56'h4000_0000 + (56'(k) << 12);
    endfunction

    initial begin
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        s_valid_i      = 1'b0;
        s_spa_i        = '0;
        s_sdid_i       = '0;
        s_access_i     = 2'd0;
        m_ready_i      = 1'b1;
        refill_valid_i = 1'b0;
        refill_spa_i   = '0;
        refill_sdid_i  = '0;
        refill_perm_i  = 3'b000;

        // Basic lookup/refill table
        tbl[0] = mk_look(56'h8000_1234, 6'd3, 2'd0, 1'b0, 1'b0);
        tbl[1] = mk_refill(56'h8000_1000, 6'd3, 3'b001);
        tbl[2] = mk_look(56'h8000_1FFC, 6'd3, 2'd0, 1'b1, 1'b1);
        tbl[3] = mk_look(56'h8000_1FFC, 6'd3, 2'd1, 1'b1, 1'b0);
        tbl[4] = mk_look(56'h8000_1FFC, 6'd3, 2'd2, 1'b1, 1'b0);
        tbl[5] = mk_look(56'h8000_1FFC, 6'd3, 2'd3, 1'b1, 1'b0);
        tbl[6] = mk_look(56'h8000_1FFC, 6'd4, 2'd0, 1'b0, 1'b0);
        // Same-cycle refill and lookup: the lookup sees the old contents.
        tbl[7] = mk_look(56'h8000_2000, 6'd3, 2'd0, 1'b0, 1'b0);
        tbl[7].rf    = 1'b1;
        tbl[7].rspa  = 56'h8000_2000;
        tbl[7].rsdid = 6'd3;
        tbl[7].rperm = 3'b111;
        tbl[8] = mk_look(56'h8000_2008, 6'd3, 2'd0, 1'b1, 1'b1);

        // Reset
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_m_valid", m_valid_o, 1'b0);
        check("rst_m_hit", m_hit_o, 1'b0);
        check("rst_m_allow", m_allow_o, 1'b0);
        check("rst_m_spa", m_spa_o, 56'h0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_s_ready", s_ready_o, 1'b1);
        check("rst_m_valid_after", m_valid_o, 1'b0);

        for (int i = 0; i < 9; i++) begin
            do_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Replacement wrap: 9 refills into 8 entries evict P0
        do_flush();
        for (int k = 0; k < 9; k++) do_vec(mk_refill(page(k), 6'd1, 3'b011), "wrap_rf");
        do_vec(mk_look(page(0), 6'd1, 2'd0, 1'b0, 1'b0), "wrap_p0");
        for (int k = 1; k < 9; k++) do_vec(mk_look(page(k), 6'd1, 2'd0, 1'b1, 1'b1), $sformatf("wrap_p%0d", k));
        // In-place refill of P3 does not evict and does not move the pointer
        do_vec(mk_refill(page(3) + 56'h123, 6'd1, 3'b100), "p3_rf");
        do_vec(mk_look(page(3), 6'd1, 2'd0, 1'b1, 1'b0), "p3_r");
        do_vec(mk_look(page(3), 6'd1, 2'd2, 1'b1, 1'b1), "p3_x");
        do_vec(mk_look(page(1), 6'd1, 2'd0, 1'b1, 1'b1), "p1_kept");
        // Pointer is at entry 1 (holding P1), so P9 must evict P1, not P2
        do_vec(mk_refill(page(9), 6'd1, 3'b011), "p9_rf");
        do_vec(mk_look(page(1), 6'd1, 2'd0, 1'b0, 1'b0), "p1_evicted");
        do_vec(mk_look(page(9), 6'd1, 2'd1, 1'b1, 1'b1), "p9_w");
        do_vec(mk_look(page(2), 6'd1, 2'd0, 1'b1, 1'b1), "p2_kept");

        // Flush colliding with refill and lookup (m_valid_o is 1 going in)
        flush_i        = 1'b1;
        refill_valid_i = 1'b1;
        refill_spa_i   = 56'h7000_0000;
        refill_sdid_i  = 6'd1;
        refill_perm_i  = 3'b111;
        s_valid_i      = 1'b1;
        s_spa_i        = page(2);
        s_sdid_i       = 6'd1;
        s_access_i     = 2'd0;
        m_ready_i      = 1'b1;
        #1;
        check("flush_s_ready", s_ready_o, 1'b0);
        @(posedge clk_i);
        #1;
        flush_i        = 1'b0;
        refill_valid_i = 1'b0;
        s_valid_i      = 1'b0;
        check("flush_m_valid", m_valid_o, 1'b0);
        do_vec(mk_look(56'h7000_0000, 6'd1, 2'd0, 1'b0, 1'b0), "flush_rf_gone");
        do_vec(mk_look(page(2), 6'd1, 2'd0, 1'b0, 1'b0), "flush_p2_gone");

        // Backpressure
        idle_cycle();
        exp_q.push_back(56'hA000);
        exp_q.push_back(56'hB000);
        exp_q.push_back(56'hC000);
        sb_en      = 1'b1;
        s_valid_i  = 1'b1;
        s_sdid_i   = 6'd2;
        s_access_i = 2'd0;
        s_spa_i    = 56'hA000;
        m_ready_i  = 1'b1;
        @(posedge clk_i);
        #1;
        check("bp_first", m_spa_o, 56'hA000);
        m_ready_i = 1'b0;
        s_spa_i   = 56'hB000;
        #1;
        check("bp_s_ready", s_ready_o, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("bp_hold_spa%0d", c), m_spa_o, 56'hA000);
            check($sformatf("bp_hold_valid%0d", c), m_valid_o, 1'b1);
            check($sformatf("bp_hold_rdy%0d", c), s_ready_o, 1'b0);
        end
        m_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("bp_b", m_spa_o, 56'hB000);
        s_spa_i = 56'hC000;
        @(posedge clk_i);
        #1;
        check("bp_c", m_spa_o, 56'hC000);
        s_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("bp_drain", m_valid_o, 1'b0);
        sb_en = 1'b0;
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef PLB_PERF_COUNTERS_EN
        do_flush();
        check("perf_clear0_hit", hit_count_o, 32'd0);
        check("perf_clear0_miss", miss_count_o, 32'd0);
        do_vec(mk_refill(56'h5000_0000, 6'd7, 3'b111), "perf_rf");
        for (int k = 0; k < 5; k++) do_vec(mk_look(56'h5000_0010 + 56'(k), 6'd7, 2'd0, 1'b1, 1'b1), "perf_hit");
        for (int k = 0; k < 2; k++) do_vec(mk_look(56'h6000_0000, 6'd7, 2'd0, 1'b0, 1'b0), "perf_miss");
        idle_cycle();
        check("perf_hit_count", hit_count_o, 32'd5);
        check("perf_miss_count", miss_count_o, 32'd2);
        do_flush();
        check("perf_flush_hit", hit_count_o, 32'd0);
        check("perf_flush_miss", miss_count_o, 32'd0);
`endif

        // Report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
